// File: rtl/scoreboard_reg_file_pkg.sv
// Shared constants and packing helpers for the scoreboarded register file.
// Default geometry matches the legacy 32x32 file.
package scoreboard_reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_READ_PORTS = 2;
  localparam int DEF_PEND_WIDTH = 2;
  localparam int ZERO_IDX       = 0;

  // Low bit of port p's field inside a packed multi-port bus.
  function automatic int sliceLo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/pending_scoreboard.sv
// Per-register pending-writer counters: reservation, commit and flush
// arithmetic, reservation stall, sticky unreserved-write error, busy lookup.
module pending_scoreboard
  import scoreboard_reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int PEND_WIDTH = DEF_PEND_WIDTH
) (
  input  logic                           clock,
  input  logic                           resetN,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] readId,
  output logic [READ_PORTS-1:0]          readBusy,
  input  logic                           writeEnable,
  input  logic [ADDR_WIDTH-1:0]          writeId,
  input  logic                           reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          reserveId,
  input  logic                           flush,
  output logic                           reserveStall,
  output logic                           writeUnreserved
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PEND_WIDTH-1:0] cnt [DEPTH];

  logic writeZero;
  logic reserveZero;
  logic writeValid;
  logic reserveAccept;
  logic writeCntZero;

  assign writeZero     = (ZERO_REG != 0) && (writeId == ADDR_WIDTH'(ZERO_IDX));
  assign reserveZero   = (ZERO_REG != 0) && (reserveId == ADDR_WIDTH'(ZERO_IDX));
  assign writeValid    = writeEnable && !writeZero;
  assign writeCntZero  = (cnt[writeId] == '0);

  // A write to the same index frees a slot in this edge, so it never stalls.
  assign reserveStall  = reserveEnable && !reserveZero && (cnt[reserveId] == '1) &&
                         !(writeEnable && (writeId == reserveId)) && !flush;
  assign reserveAccept = reserveEnable && !reserveZero && !reserveStall;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) cnt[i] <= '0;
      writeUnreserved <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          cnt[i] <= (reserveAccept && (reserveId == ADDR_WIDTH'(i))) ? PEND_WIDTH'(1) : '0;
        end else if (reserveAccept && (reserveId == ADDR_WIDTH'(i)) &&
                     !(writeValid && (writeId == ADDR_WIDTH'(i)) && (cnt[i] != '0))) begin
          cnt[i] <= cnt[i] + PEND_WIDTH'(1);
        end else if (!(reserveAccept && (reserveId == ADDR_WIDTH'(i))) &&
                     writeValid && (writeId == ADDR_WIDTH'(i)) && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - PEND_WIDTH'(1);
        end
      end
      if (writeValid && !flush && writeCntZero) writeUnreserved <= 1'b1;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] id;
    logic [PEND_WIDTH-1:0] c;
    id       = '0;
    c        = '0;
    readBusy = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      id = readId[sliceLo(p, ADDR_WIDTH) +: ADDR_WIDTH];
      c  = cnt[id];
      if ((ZERO_REG != 0) && (id == ADDR_WIDTH'(ZERO_IDX))) begin
        readBusy[p] = 1'b0;
      end else if ((BYPASS != 0) && writeValid && (writeId == id)) begin
        // The committing writer is already visible through the bypass.
        readBusy[p] = (c > PEND_WIDTH'(1));
      end else begin
        readBusy[p] = (c != '0);
      end
    end
  end

endmodule

// File: rtl/scoreboard_reg_file.sv
// Multi-port register file with optional zero register and write bypass,
// plus a pending-writer scoreboard for the issue stage.
module scoreboard_reg_file
  import scoreboard_reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int READ_PORTS = DEF_READ_PORTS,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int PEND_WIDTH = DEF_PEND_WIDTH
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] ReadID,
  output logic [READ_PORTS*DATA_WIDTH-1:0] ReadData,
  output logic [READ_PORTS-1:0]            ReadBusy,
  input  logic                             WriteEnable,
  input  logic [ADDR_WIDTH-1:0]            WriteID,
  input  logic [DATA_WIDTH-1:0]            WriteData,
  input  logic                             ReserveEnable,
  input  logic [ADDR_WIDTH-1:0]            ReserveID,
  output logic                             ReserveStall,
  input  logic                             Flush,
  output logic                             WriteUnreserved
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  writeValid;

  assign writeValid = WriteEnable &&
                      !((ZERO_REG != 0) && (WriteID == ADDR_WIDTH'(ZERO_IDX)));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (writeValid) begin
      regs[WriteID] <= WriteData;
    end
  end

  // Bypass is gated by Reset so every port reads 0 while reset is held.
  always_comb begin
    logic [ADDR_WIDTH-1:0] id;
    id       = '0;
    ReadData = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      id = ReadID[sliceLo(p, ADDR_WIDTH) +: ADDR_WIDTH];
      if ((ZERO_REG != 0) && (id == ADDR_WIDTH'(ZERO_IDX))) begin
        ReadData[sliceLo(p, DATA_WIDTH) +: DATA_WIDTH] = '0;
      end else if ((BYPASS != 0) && Reset && writeValid && (WriteID == id)) begin
        ReadData[sliceLo(p, DATA_WIDTH) +: DATA_WIDTH] = WriteData;
      end else begin
        ReadData[sliceLo(p, DATA_WIDTH) +: DATA_WIDTH] = regs[id];
      end
    end
  end

  pending_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .READ_PORTS (READ_PORTS),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS),
    .PEND_WIDTH (PEND_WIDTH)
  ) uScoreboard (
    .clock           (Clock),
    .resetN          (Reset),
    .readId          (ReadID),
    .readBusy        (ReadBusy),
    .writeEnable     (WriteEnable),
    .writeId         (WriteID),
    .reserveEnable   (ReserveEnable),
    .reserveId       (ReserveID),
    .flush           (Flush),
    .reserveStall    (ReserveStall),
    .writeUnreserved (WriteUnreserved)
  );

endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Bench for scoreboard_reg_file (default parameters): directed vector table,
// an asynchronous-reset sequence, then random stimulus against a reference model.
module tb_scoreboard_reg_file;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [9:0]  ReadID;
  logic [63:0] ReadData;
  logic [1:0]  ReadBusy;
  logic        WriteEnable;
  logic [4:0]  WriteID;
  logic [31:0] WriteData;
  logic        ReserveEnable;
  logic [4:0]  ReserveID;
  logic        ReserveStall;
  logic        Flush;
  logic        WriteUnreserved;

  always #5 Clock = ~Clock;

  scoreboard_reg_file dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .ReadID          (ReadID),
    .ReadData        (ReadData),
    .ReadBusy        (ReadBusy),
    .WriteEnable     (WriteEnable),
    .WriteID         (WriteID),
    .WriteData       (WriteData),
    .ReserveEnable   (ReserveEnable),
    .ReserveID       (ReserveID),
    .ReserveStall    (ReserveStall),
    .Flush           (Flush),
    .WriteUnreserved (WriteUnreserved)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wid;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  rid;
    logic        fl;
    logic [4:0]  id0;
    logic [4:0]  id1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic        st;
    logic        un;
  } vec_t;

  vec_t tbl[$];

  // Reference model: plain integer counters and a value array.
  logic [31:0] mRegs [32];
  int          mCnt  [32];
  bit          mUnres;

  task automatic modelClear();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = '0;
      mCnt[i]  = 0;
    end
    mUnres = 0;
  endtask

  function automatic logic [31:0] expData(input int id);
    if (id == 0) return '0;
    if (Reset && WriteEnable && int'(WriteID) == id) return WriteData;
    return mRegs[id];
  endfunction

  function automatic logic expBusy(input int id);
    int c;
    if (id == 0) return 1'b0;
    c = mCnt[id];
    if (WriteEnable && int'(WriteID) == id && c > 0) c = c - 1;
    return c > 0;
  endfunction

  function automatic logic expStall();
    return ReserveEnable && ReserveID != 0 && mCnt[ReserveID] == 3 &&
           !(WriteEnable && WriteID == ReserveID) && !Flush;
  endfunction

  task automatic modelEdge();
    bit stall;
    bit wValid;
    if (!Reset) return;
    stall  = expStall();
    wValid = WriteEnable && WriteID != 0;
    if (wValid) begin
      mRegs[WriteID] = WriteData;
      if (!Flush && mCnt[WriteID] == 0) mUnres = 1;
    end
    if (Flush) begin
      for (int i = 0; i < 32; i++) mCnt[i] = 0;
      if (ReserveEnable && ReserveID != 0) mCnt[ReserveID] = 1;
    end else begin
      if (wValid && mCnt[WriteID] > 0) mCnt[WriteID] = mCnt[WriteID] - 1;
      if (ReserveEnable && ReserveID != 0 && !stall) mCnt[ReserveID] = mCnt[ReserveID] + 1;
    end
  endtask

  task automatic idleInputs();
    ReadID        = '0;
    WriteEnable   = 1'b0;
    WriteID       = '0;
    WriteData     = '0;
    ReserveEnable = 1'b0;
    ReserveID     = '0;
    Flush         = 1'b0;
  endtask

  initial begin
    idleInputs();
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    //            we wid wd            re rid fl id0 id1  d0            b0 d1            b1 st un
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 5, 31,  32'h0,        0, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 7, 0, 7, 5,   32'h0,        0, 32'h0,        0, 0, 0});
    tbl.push_back('{1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 5,   32'hDEADBEEF, 0, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 7, 7,   32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 3, 0, 3, 7,   32'h0,        0, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 3, 0, 3, 7,   32'h0,        1, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 3, 0, 3, 7,   32'h0,        1, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 3, 0, 3, 7,   32'h0,        1, 32'hDEADBEEF, 0, 1, 0});
    tbl.push_back('{1, 3, 32'h55,       1, 3, 0, 3, 7,   32'h55,       1, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 3, 0, 3, 7,   32'h55,       1, 32'hDEADBEEF, 0, 1, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 3, 1, 3, 7,   32'h55,       1, 32'hDEADBEEF, 0, 0, 0});
    tbl.push_back('{1, 0, 32'h1234,     1, 0, 0, 0, 0,   32'h0,        0, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 0, 3,   32'h0,        0, 32'h55,       1, 0, 0});
    tbl.push_back('{1, 3, 32'h66,       0, 0, 0, 3, 0,   32'h66,       0, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 4, 0, 4, 9,   32'h0,        0, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 9, 0, 4, 9,   32'h0,        1, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        1, 12, 1, 4, 9,  32'h0,        1, 32'h0,        1, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 4, 9,   32'h0,        0, 32'h0,        0, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 12, 4,  32'h0,        1, 32'h0,        0, 0, 0});
    tbl.push_back('{1, 4, 32'hAA,       0, 0, 0, 4, 12,  32'hAA,       0, 32'h0,        1, 0, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 0, 0, 4, 12,  32'hAA,       0, 32'h0,        1, 0, 1});

    foreach (tbl[i]) begin
      WriteEnable   = tbl[i].we;
      WriteID       = tbl[i].wid;
      WriteData     = tbl[i].wd;
      ReserveEnable = tbl[i].re;
      ReserveID     = tbl[i].rid;
      Flush         = tbl[i].fl;
      ReadID        = {tbl[i].id1, tbl[i].id0};
      @(negedge Clock);
      check($sformatf("row%0d data0", i), ReadData[31:0], tbl[i].d0);
      check($sformatf("row%0d busy0", i), 32'(ReadBusy[0]), 32'(tbl[i].b0));
      check($sformatf("row%0d data1", i), ReadData[63:32], tbl[i].d1);
      check($sformatf("row%0d busy1", i), 32'(ReadBusy[1]), 32'(tbl[i].b1));
      check($sformatf("row%0d stall", i), 32'(ReserveStall), 32'(tbl[i].st));
      check($sformatf("row%0d unres", i), 32'(WriteUnreserved), 32'(tbl[i].un));
      @(posedge Clock);
      #1;
    end

    // Asynchronous reset with data written, count on 12 and the error flag set.
    idleInputs();
    ReadID      = {5'd12, 5'd4};
    WriteEnable = 1'b1;
    WriteID     = 5'd4;
    WriteData   = 32'hBEEF;
    #2 Reset = 1'b0;
    #1;
    check("async rst data0", ReadData[31:0], 32'h0);
    check("async rst data1", ReadData[63:32], 32'h0);
    check("async rst busy", 32'(ReadBusy), 32'h0);
    check("async rst unres", 32'(WriteUnreserved), 32'h0);
    @(posedge Clock);
    #1;
    Reset       = 1'b1;
    WriteEnable = 1'b0;
    @(negedge Clock);
    check("post rst data4", ReadData[31:0], 32'h0);
    check("post rst busy12", 32'(ReadBusy[1]), 32'h0);
    @(posedge Clock);
    #1;

    // Random phase: small index range to force collisions and saturation.
    modelClear();
    for (int n = 0; n < 3000; n++) begin
      Reset         = ($urandom_range(0, 199) != 0);
      WriteEnable   = ($urandom_range(0, 2) == 0);
      WriteID       = 5'($urandom_range(0, 7));
      WriteData     = $urandom;
      ReserveEnable = ($urandom_range(0, 1) == 1);
      ReserveID     = 5'($urandom_range(0, 7));
      Flush         = ($urandom_range(0, 29) == 0);
      ReadID        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      if (!Reset) modelClear();
      @(negedge Clock);
      check("rand data0", ReadData[31:0], expData(int'(ReadID[4:0])));
      check("rand data1", ReadData[63:32], expData(int'(ReadID[9:5])));
      check("rand busy0", 32'(ReadBusy[0]), 32'(expBusy(int'(ReadID[4:0]))));
      check("rand busy1", 32'(ReadBusy[1]), 32'(expBusy(int'(ReadID[9:5]))));
      check("rand stall", 32'(ReserveStall), 32'(expStall()));
      check("rand unres", 32'(WriteUnreserved), 32'(mUnres));
      @(posedge Clock);
      modelEdge();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
